// File: rtl/serial_pattern_gen.sv
// -----------------------------------------------------------------------------
// serial_pattern_gen
//   Serial stimulus source for the sequence-detector machines. On an accepted
//   start it latches a PAT_W-bit pattern and a repeat count, then shifts the
//   pattern out MSB-first, one bit per clock, repeat_n times. GAP_CYC idle
//   cycles separate consecutive repeats. A single FIN cycle pulses done.
//
// Parameters
//   PAT_W    pattern length in bits (>= 2)
//   CNT_W    width of repeat_n
//   GAP_CYC  idle cycles between repeats (0 = back-to-back)
//
// Ports
//   clk       in   1      system clock, posedge
//   rst       in   1      synchronous reset, active-high
//   start     in   1      transmission request, sampled only in IDLE
//   pattern   in   PAT_W  bits to send, MSB first, latched on accepted start
//   repeat_n  in   CNT_W  number of repeats, latched on accepted start
//   x         out  1      serial data bit (registered, 0 when valid=0)
//   valid     out  1      x carries a pattern bit
//   busy      out  1      transmission in progress (low in FIN)
//   done      out  1      one-cycle pulse when a transmission finishes
// -----------------------------------------------------------------------------
module serial_pattern_gen #(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
  // Only meaningful when GAP_CYC > 0; the GAP state is unreachable otherwise.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t             state_reg,   state_next;
  logic [PAT_W-1:0]   pat_reg,     pat_next;      // latched pattern, reloaded per repeat
  logic [PAT_W-1:0]   shift_reg,   shift_next;    // remaining bits of current repeat, MSB next
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;  // index of the bit currently on x
  logic [CNT_W-1:0]   rep_cnt_reg, rep_cnt_next;  // repeats left, including the current one
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               x_reg,       x_next;
  logic               valid_reg,   valid_next;
  logic               busy_reg,    busy_next;
  logic               done_reg,    done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pat_reg     <= '0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      rep_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      x_reg       <= 1'b0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pat_reg     <= pat_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      rep_cnt_reg <= rep_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      x_reg       <= x_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Outputs are computed one cycle ahead here and registered above, so every
  // branch that enters a state also sets that state's output values.
  always_comb begin
    state_next   = state_reg;
    pat_next     = pat_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    rep_cnt_next = rep_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    x_next       = 1'b0;
    valid_next   = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (repeat_n != '0) begin
            pat_next     = pattern;
            shift_next   = pattern << 1;
            bit_cnt_next = '0;
            rep_cnt_next = repeat_n;
            x_next       = pattern[PAT_W-1];
            valid_next   = 1'b1;
            busy_next    = 1'b1;
            state_next   = ST_SEND;
          end else begin
            // Empty transmission: straight to the done pulse, never busy.
            done_next  = 1'b1;
            state_next = ST_FIN;
          end
        end
      end

      ST_SEND: begin
        if (bit_cnt_reg == LAST_BIT) begin
          if (rep_cnt_reg != CNT_W'(1)) begin
            // Counting down from the latched value cannot wrap, even at 2^CNT_W-1.
            rep_cnt_next = rep_cnt_reg - 1'b1;
            busy_next    = 1'b1;
            if (GAP_CYC > 0) begin
              gap_cnt_next = '0;
              state_next   = ST_GAP;
            end else begin
              x_next       = pat_reg[PAT_W-1];
              shift_next   = pat_reg << 1;
              bit_cnt_next = '0;
              valid_next   = 1'b1;
            end
          end else begin
            done_next  = 1'b1;
            state_next = ST_FIN;
          end
        end else begin
          x_next       = shift_reg[PAT_W-1];
          shift_next   = shift_reg << 1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          valid_next   = 1'b1;
          busy_next    = 1'b1;
        end
      end

      ST_GAP: begin
        busy_next = 1'b1;
        if (gap_cnt_reg == GAP_LAST) begin
          x_next       = pat_reg[PAT_W-1];
          shift_next   = pat_reg << 1;
          bit_cnt_next = '0;
          valid_next   = 1'b1;
          state_next   = ST_SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      ST_FIN: begin
        // start is deliberately ignored here; only IDLE accepts a request.
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign x     = x_reg;
  assign valid = valid_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule
